// File: rtl/reg_pipe_skid_rst_y_mode_s.sv
// Valid/ready pipeline register with a 2-entry skid buffer; o_ready is a pure state decode.
// Optional beat counter o_cnt is built only when REG_PIPE_SKID_CNT_EN is defined.
module reg_pipe_skid_rst_y_mode_s #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef REG_PIPE_SKID_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_cnt
`endif
);

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // o_valid/o_ready depend only on state, never on i_valid/i_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] skid;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_fire) state_nxt = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_nxt = FULL;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      FULL:    if (out_fire) state_nxt = BUSY;
      default: state_nxt = EMPTY;
    endcase
  end

  // o_valid/o_ready are registered decodes of the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      o_data  <= '0;
      skid    <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt != EMPTY);
      o_ready <= (state_nxt != FULL);
      case (state)
        EMPTY: if (in_fire) o_data <= i_data;
        BUSY: begin
          if (in_fire && out_fire) o_data <= i_data;
          else if (in_fire)        skid   <= i_data;
        end
        FULL:    if (out_fire) o_data <= skid;
        default: ;
      endcase
    end
  end

`ifdef REG_PIPE_SKID_CNT_EN
  // Wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      o_cnt <= '0;
    else if (out_fire) o_cnt <= o_cnt + 1'b1;
  end
`endif

endmodule
